// File: rtl/log_pkg.sv
// Shared types and scale constants for the iterative logarithm unit.
// Constants are kept at 32 fractional bits and rounded to the configured precision.
package log_pkg;

  typedef enum logic [2:0] {
    MODE_FLOOR = 3'd0,
    MODE_CEIL  = 3'd1,
    MODE_LOG2  = 3'd2,
    MODE_LN    = 3'd3,
    MODE_LOG10 = 3'd4
  } log_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_FRAC,
    S_SCALE,
    S_DONE
  } state_e;

  localparam int unsigned LN2_Q     = 45426;
  localparam int unsigned LOG10_2_Q = 19728;

  localparam logic [31:0] LN2_Q32     = 32'd2977044472;
  localparam logic [31:0] LOG10_2_Q32 = 32'd1292913986;

  // Round a 32-fractional-bit constant to 'bits' fractional bits (1..31).
  function automatic logic [32:0] scale_const(input logic [31:0] c32, input int unsigned bits);
    logic [32:0] r;
    r = {1'b0, c32} + (33'd1 << (31 - bits));
    return r >> (32 - bits);
  endfunction

endpackage

// File: rtl/log2_frac_step.sv
// One fractional-bit step of log2 by repeated squaring of a Q1.(WIDTH-1) mantissa.
// Emits the next fraction bit and the renormalised mantissa.
module log2_frac_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] m_next,
  output logic             frac_bit
);

  logic [WIDTH:0] sq_top;

  // Top WIDTH+1 bits of m*m, viewed as Q2.(WIDTH-1)
  assign sq_top   = (WIDTH+1)'(((2*WIDTH)'(m) * (2*WIDTH)'(m)) >> (WIDTH - 1));
  assign frac_bit = sq_top[WIDTH];
  assign m_next   = frac_bit ? sq_top[WIDTH:1] : sq_top[WIDTH-1:0];

endmodule

// File: rtl/log_unit_seq.sv
// Iterative log engine: normalise, extract fraction bits by squaring, then scale
// to floor/ceil log2, log2, ln or log10 in unsigned fixed point.
module log_unit_seq
  import log_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC_BITS  = 8,
  parameter int CONST_BITS = 16,
  parameter int RW         = $clog2(WIDTH) + 1 + FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_result,
  output logic             out_err,
  output logic             busy
);

  localparam int EW = $clog2(WIDTH);
  localparam int LW = EW + FRAC_BITS;
  localparam int CW = $clog2(FRAC_BITS) + 1;

  localparam logic [CONST_BITS-1:0] LN2_C     = CONST_BITS'(scale_const(LN2_Q32, CONST_BITS));
  localparam logic [CONST_BITS-1:0] LOG10_2_C = CONST_BITS'(scale_const(LOG10_2_Q32, CONST_BITS));

  state_e                state, state_nxt;
  logic [WIDTH-1:0]      m;
  logic [EW-1:0]         e;
  log_mode_e             mode;
  logic                  pow2;
  logic [FRAC_BITS-1:0]  frac;
  logic [CW-1:0]         cnt;
  logic [RW-1:0]         result;
  logic                  err;
  logic [WIDTH-1:0]      m_sq;
  logic                  frac_bit;
  logic                  bad_op;
  logic [LW-1:0]         l_val;
  logic [EW:0]           e_ceil;

  function automatic logic [RW-1:0] scale_round(input logic [LW-1:0] l, input logic [CONST_BITS-1:0] c);
    return RW'(((LW+CONST_BITS)'(l) * (LW+CONST_BITS)'(c)
                + ((LW+CONST_BITS)'(1) << (CONST_BITS - 1))) >> CONST_BITS);
  endfunction

  log2_frac_step #(.WIDTH(WIDTH)) u_step (
    .m        (m),
    .m_next   (m_sq),
    .frac_bit (frac_bit)
  );

  assign bad_op = (in_data == '0) || (in_mode > 3'd4);
  assign l_val  = {e, frac};
  assign e_ceil = {1'b0, e} + {{EW{1'b0}}, ~pow2};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    out_result = result;
    out_err    = err;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = bad_op ? S_DONE : S_NORM;
      end
      S_NORM: begin
        if (m[WIDTH-1])
          state_nxt = (mode == MODE_FLOOR || mode == MODE_CEIL) ? S_SCALE : S_FRAC;
      end
      S_FRAC:  if (cnt == '0) state_nxt = S_SCALE;
      S_SCALE: state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m      <= '0;
      e      <= '0;
      mode   <= MODE_FLOOR;
      pow2   <= 1'b0;
      frac   <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          m      <= in_data;
          e      <= EW'(WIDTH - 1);
          mode   <= log_mode_e'(in_mode);
          pow2   <= 1'b0;
          frac   <= '0;
          cnt    <= CW'(FRAC_BITS - 1);
          result <= '0;
          err    <= bad_op;
        end
        S_NORM: begin
          if (!m[WIDTH-1]) begin
            m <= m << 1;
            e <= e - 1'b1;
          end else begin
            pow2 <= ~|m[WIDTH-2:0];
          end
        end
        S_FRAC: begin
          m    <= m_sq;
          frac <= FRAC_BITS'({frac, frac_bit});
          cnt  <= cnt - 1'b1;
        end
        S_SCALE: begin
          case (mode)
            MODE_FLOOR: result <= RW'({e, {FRAC_BITS{1'b0}}});
            MODE_CEIL:  result <= {e_ceil, {FRAC_BITS{1'b0}}};
            MODE_LOG2:  result <= RW'(l_val);
            MODE_LN:    result <= scale_round(l_val, LN2_C);
            MODE_LOG10: result <= scale_round(l_val, LOG10_2_C);
            default:    result <= '0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log_unit_seq.sv
// Self-checking bench for log_unit_seq against a numeric log model.
module tb_log_unit_seq;

  localparam int WIDTH      = 32;
  localparam int FRAC_BITS  = 8;
  localparam int CONST_BITS = 16;
  localparam int RW         = $clog2(WIDTH) + 1 + FRAC_BITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [2:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RW-1:0]    out_result;
  logic             out_err;
  logic             busy;

  int checks = 0;
  int errors = 0;
  longint unsigned ln2_q, log10_q;

  always #5 clk = ~clk;

  log_unit_seq #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .CONST_BITS(CONST_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .busy(busy)
  );

  // Reference: log2 by bit search, fraction via truncated repeated squaring, then plain scaling.
  task automatic ref_model(input logic [WIDTH-1:0] d, input int mode,
                           output longint unsigned res, output bit err, output int lat);
    int msb;
    longint unsigned m, sq, q, frac, l;
    bit p2;
    res = 0; err = 0; lat = 1;
    if (d == 0 || mode > 4) begin
      err = 1;
      return;
    end
    msb = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) begin msb = i; break; end
    p2 = ((d & (d - 1)) == 0);
    m = longint'(d) << (WIDTH - 1 - msb);
    frac = 0;
    for (int k = 0; k < FRAC_BITS; k++) begin
      sq = m * m;
      q  = sq >> (WIDTH - 1);
      if (q >= (64'd1 << WIDTH)) begin frac = frac * 2 + 1; m = q >> 1; end
      else                       begin frac = frac * 2;     m = q;      end
    end
    l = longint'(msb) * (64'd1 << FRAC_BITS) + frac;
    case (mode)
      0: res = longint'(msb) << FRAC_BITS;
      1: res = longint'(msb + (p2 ? 0 : 1)) << FRAC_BITS;
      2: res = l;
      3: res = (l * ln2_q + (64'd1 << (CONST_BITS - 1))) >> CONST_BITS;
      default: res = (l * log10_q + (64'd1 << (CONST_BITS - 1))) >> CONST_BITS;
    endcase
    lat = (mode < 2) ? (WIDTH - msb + 2) : (WIDTH - msb + FRAC_BITS + 2);
  endtask

  // Issue one operand, wait for its result, check it and complete the handshake.
  task automatic run_op(input logic [WIDTH-1:0] d, input int mode, input string tag);
    longint unsigned exp_res;
    bit exp_err;
    int exp_lat, lat;
    ref_model(d, mode, exp_res, exp_err, exp_lat);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before issue: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; in_data = d; in_mode = 3'(mode);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom; in_mode = 3'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy after accept: got %b want 1", tag, busy);
    end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (out_valid !== 1'b1 || lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency d=%0h mode=%0d: got %0d want %0d", tag, d, mode, lat, exp_lat);
    end
    checks++;
    if (out_result !== RW'(exp_res) || out_err !== exp_err) begin
      errors++;
      $display("FAIL %s result d=%0h mode=%0d: got %0d/err%b want %0d/err%b",
               tag, d, mode, out_result, out_err, exp_res, exp_err);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got in_ready=%b out_valid=%b want 1/0", tag, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%0d err=%b busy=%b want 1/0/0/0/0",
               in_ready, out_valid, out_result, out_err, busy);
    end
  endtask

  task automatic test_known();
    for (int md = 0; md < 5; md++) run_op(32'd123, md, "known_123");
    for (int md = 0; md < 3; md++) run_op(32'd64, md, "known_64");
    for (int md = 0; md < 3; md++) run_op(32'd1, md, "known_1");
    for (int md = 0; md < 3; md++) run_op(32'hFFFF_FFFF, md, "known_max");
    for (int md = 0; md < 5; md++) run_op(32'd0, md, "zero");
    run_op(32'd123, 6, "reserved_mode");
    run_op(32'h8000_0000, 1, "ceil_top_pow2");
    run_op(32'h8000_0001, 1, "ceil_top_npow2");
  endtask

  task automatic test_backpressure();
    int n;
    in_valid = 1'b1; in_data = 32'd123; in_mode = 3'd2;
    @(posedge clk); #1;
    in_data = 32'd77; in_mode = 3'd0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== RW'(1777) || out_err !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got vld=%b res=%0d err=%b rdy=%b want 1/1777/0/0",
                 i, out_valid, out_result, out_err, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure release: got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ops_d[6] = '{32'd123, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'd1000, 32'd2};
    int ops_m[6] = '{2, 3, 0, 4, 1, 3};
    longint unsigned exp_q[$];
    longint unsigned r;
    bit er;
    int lt, idx, ridx, cyc;
    bit acc, fire;
    for (int i = 0; i < 6; i++) begin
      ref_model(ops_d[i], ops_m[i], r, er, lt);
      exp_q.push_back(r | (longint'(er) << 40));
    end
    idx = 0; ridx = 0; cyc = 0;
    out_ready = 1'b1;
    while (ridx < 6 && cyc < 1000) begin
      in_valid = (idx < 6);
      in_data  = (idx < 6) ? ops_d[idx] : '0;
      in_mode  = (idx < 6) ? 3'(ops_m[idx]) : 3'd0;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        checks++;
        if ({out_err, out_result} !== {exp_q[ridx][40], RW'(exp_q[ridx])}) begin
          errors++;
          $display("FAIL back_to_back result %0d: got %0d/err%b want %0d/err%b",
                   ridx, out_result, out_err, RW'(exp_q[ridx]), exp_q[ridx][40]);
        end
        ridx++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (ridx != 6 || idx != 6) begin
      errors++;
      $display("FAIL back_to_back count: got accepted=%0d results=%0d want 6/6", idx, ridx);
    end
  endtask

  task automatic test_reset_mid_frac();
    in_valid = 1'b1; in_data = 32'd123; in_mode = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_frac: got vld=%b busy=%b rdy=%b want 0/0/1", out_valid, busy, in_ready);
    end
    repeat (40) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_frac stray result: got vld=%b want 0", out_valid);
      end
    end
    run_op(32'd123, 2, "after_reset");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 400; i++) begin
      d = $urandom >> $urandom_range(0, WIDTH - 1);
      for (int md = 0; md < 5; md++) run_op(d, md, "random");
    end
    for (int i = 0; i < 20; i++) run_op($urandom, $urandom_range(5, 7), "random_reserved");
  endtask

  initial begin
    ln2_q   = longint'($rtoi($ln(2.0) * 65536.0 + 0.5));
    log10_q = longint'($rtoi($log10(2.0) * 65536.0 + 0.5));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_known();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frac();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
